// File: rtl/soc_ctrl_delay_arbiter.sv
// Round-robin owner of one shared down-counter: IDLE -> RUN (count delay) -> DONE (pulse) -> IDLE.
// Optional: define SOC_CTRL_DELAY_ARB_ABORT_EN to release the counter when the owner drops its request.
module soc_ctrl_delay_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DELAY_W = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0][DELAY_W-1:0] delay_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            busy_o,
  output logic [DELAY_W-1:0]              count_o
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      last_q, last_d, win, rr_idx;
  logic               win_vld, abort;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;

  // Search from last_owner+1 upward with wrap; the previous owner is checked last.
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    rr_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = OW'((int'(last_q) + i) % NUM_REQ);
      if (!win_vld && req_i[rr_idx]) begin
        win_vld = 1'b1;
        win     = rr_idx;
      end
    end
  end

  // last_q always names the current owner while RUN/DONE.
`ifdef SOC_CTRL_DELAY_ARB_ABORT_EN
  assign abort = !req_i[last_q];
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = RUN;
          gnt_d   = NUM_REQ'(1) << win;
          cnt_d   = delay_i[win];
          last_d  = win;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      cnt_q   <= '0;
      last_q  <= OW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign done_o  = (state_q == DONE) ? gnt_q : '0;
  assign busy_o  = (state_q != IDLE);
  assign count_o = cnt_q;

endmodule
